secuenciador_potencia: RTL

Clocked controller for one power-analysis run over the adder transition-counter memory.
- On `start` it clears every transition counter through the memory port (LE low = write).
- It then drives NUM_SUMAS pseudo-random operand pairs to all adders under test, holding each pair PERIODO cycles.
- It then reads every counter back (LE high = read) and streams the values out.
- It replaces the behavioural initial-block sequencing so runs are repeatable and synthesizable.

---
 rtl/secuenciador_pkg.sv | 21 ++
 rtl/lfsr16_galois.sv | 30 +++
 rtl/secuenciador_potencia.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/secuenciador_pkg.sv
// Shared definitions for the power-analysis sequencer: state encoding and LFSR constants.
package secuenciador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_READ   = 3'd4,
        ST_DONE   = 3'd5
    } estado_t;

    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] SEED_ZERO_SUB = 16'h0001;

    // An all-zero Galois LFSR never leaves zero, so a zero seed is swapped out.
    function automatic logic [15:0] fixSeed(input logic [15:0] seed);
        return (seed == 16'h0000) ? SEED_ZERO_SUB : seed;
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR with synchronous load; reset and load both take the seed.
module lfsr16_galois
    import secuenciador_pkg::*;
(
    input  logic        clk,
    input  logic        reset_L,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] r_lfsr;
    logic [15:0] w_seed;
    logic [15:0] w_shifted;

    assign w_seed    = fixSeed(seed);
    assign w_shifted = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

    always_ff @(posedge clk) begin
        if (!reset_L || load) begin
            r_lfsr <= w_seed;
        end else if (step) begin
            r_lfsr <= w_shifted;
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/secuenciador_potencia.sv
// Power-analysis run sequencer: clear counters, apply LFSR operand pairs, read counters back.
// Optional SECUENCIADOR_TOTAL_EN adds total_trans, the sum of all readout beats of the run.
module secuenciador_potencia
    import secuenciador_pkg::*;
#(
    parameter int          NUM_CNTR  = 3,
    parameter int          DIR_W     = 2,
    parameter int          DATA_W    = 32,
    parameter int          OPR_W     = 8,
    parameter int          NUM_SUMAS = 101,
    parameter int          PERIODO   = 4,
    parameter logic [15:0] SEMILLA   = 16'h000A
)(
    input  logic              clk,
    input  logic              reset_L,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [OPR_W-1:0]  opr_a,
    output logic [OPR_W-1:0]  opr_b,
    output logic              opr_valid,
    output logic [15:0]       sum_count,
    output logic [DIR_W-1:0]  mem_dir,
    output logic              mem_le,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cnt_valid,
    output logic [DIR_W-1:0]  cnt_dir,
`ifdef SECUENCIADOR_TOTAL_EN
    output logic [DATA_W+DIR_W-1:0] total_trans,
`endif
    output logic [DATA_W-1:0] cnt_data
);

    localparam int HOLD_W = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int PAIR_W = (NUM_SUMAS > 0) ? $clog2(NUM_SUMAS + 1) : 1;
    localparam int TOT_W  = DATA_W + DIR_W;

    estado_t r_state;
    estado_t w_next;

    logic [DIR_W-1:0]  r_dir;
    logic [HOLD_W-1:0] r_hold;
    logic [PAIR_W-1:0] r_pairCnt;
    logic [15:0]       r_sumCount;
    logic [OPR_W-1:0]  r_oprA;
    logic [OPR_W-1:0]  r_oprB;
    logic              r_cntValid;
    logic [DIR_W-1:0]  r_cntDir;
    logic [DATA_W-1:0] r_cntData;

    logic        w_pairStart;
    logic        w_dirLast;
    logic        w_holdLast;
    logic        w_pairsDone;
    logic        w_stateChange;
    logic        w_lfsrLoad;
    logic [15:0] w_lfsr;

    assign w_dirLast     = (r_dir == DIR_W'(NUM_CNTR - 1));
    assign w_holdLast    = (r_hold == HOLD_W'(PERIODO - 1));
    assign w_pairsDone   = (r_pairCnt == PAIR_W'(NUM_SUMAS));
    assign w_stateChange = (r_state != w_next);
    assign w_lfsrLoad    = (r_state == ST_IDLE);

    lfsr16_galois u_lfsr (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (w_lfsrLoad),
        .seed    (SEMILLA),
        .step    (w_pairStart),
        .value   (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // w_pairStart marks the edge that latches a new operand pair and advances the LFSR.
    always_comb begin
        w_next      = r_state;
        w_pairStart = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_dirLast) begin
                    if (NUM_SUMAS == 0) begin
                        w_next = ST_SETTLE;
                    end else begin
                        w_next      = ST_RUN;
                        w_pairStart = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_holdLast) begin
                    if (w_pairsDone) begin
                        w_next = ST_SETTLE;
                    end else begin
                        w_pairStart = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_holdLast) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                if (w_dirLast) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_dir      <= '0;
            r_hold     <= '0;
            r_pairCnt  <= '0;
            r_sumCount <= '0;
            r_oprA     <= '0;
            r_oprB     <= '0;
            r_cntValid <= 1'b0;
            r_cntDir   <= '0;
            r_cntData  <= '0;
        end else begin
            if (w_stateChange) begin
                r_dir <= '0;
            end else if (r_state == ST_CLEAR || r_state == ST_READ) begin
                r_dir <= r_dir + 1'b1;
            end

            if (w_stateChange || w_pairStart) begin
                r_hold <= '0;
            end else if (r_state == ST_RUN || r_state == ST_SETTLE) begin
                r_hold <= r_hold + 1'b1;
            end

            if (r_state == ST_IDLE) begin
                r_pairCnt  <= '0;
                r_sumCount <= '0;
            end else if (w_pairStart) begin
                r_pairCnt <= r_pairCnt + 1'b1;
                if (r_sumCount != 16'hFFFF) begin
                    r_sumCount <= r_sumCount + 16'd1;
                end
            end

            if (w_pairStart) begin
                r_oprA <= OPR_W'(w_lfsr[15:8]);
                r_oprB <= OPR_W'(w_lfsr[7:0]);
            end

            // Readout lags the address by one cycle, so the last beat lands in DONE.
            r_cntValid <= (r_state == ST_READ);
            if (r_state == ST_READ) begin
                r_cntDir  <= r_dir;
                r_cntData <= mem_rdata;
            end
        end
    end

`ifdef SECUENCIADOR_TOTAL_EN
    logic [TOT_W-1:0] r_total;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_total <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_total <= '0;
        end else if (r_state == ST_READ) begin
            r_total <= r_total + TOT_W'(mem_rdata);
        end
    end

    assign total_trans = r_total;
`endif

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign mem_le    = (r_state != ST_CLEAR);
    assign mem_wdata = '0;
    assign mem_dir   = r_dir;
    assign opr_valid = (r_state == ST_RUN) && (r_hold == '0);
    assign opr_a     = r_oprA;
    assign opr_b     = r_oprB;
    assign sum_count = r_sumCount;
    assign cnt_valid = r_cntValid;
    assign cnt_dir   = r_cntDir;
    assign cnt_data  = r_cntData;

endmodule
